ifetch_line_buffer: RTL and testbench

- CPU-side initiator for the slow instruction-memory start/rdy read protocol. The memory is the responder.
- Holds one 16-byte instruction line and serves 32-bit instructions to the fetch stage.
- On a miss it issues a line read and forwards the requested word when the line returns.
- Sits between the CPU fetch stage and the slow instruction memory port.

---
 rtl/ifetch_line_buffer.sv | 148 ++++++++++++++
 tb/tb_ifetch_line_buffer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_line_buffer.sv
// Single-line instruction buffer: serves 32-bit words to fetch from one cached
// line and refills that line over the start/rdy instruction-memory protocol.
module ifetch_line_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BYTES = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   pc,
    input  logic                    pc_valid,
    input  logic                    flush,
    output logic [31:0]             instr,
    output logic                    instr_valid,
    output logic                    misaligned,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    miss_count,
    output logic                    imem_read_start,
    output logic [ADDR_WIDTH-1:0]   imem_read_addr,
    input  logic [LINE_BYTES*8-1:0] imem_read_data,
    input  logic                    imem_read_rdy
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int TAG_W  = ADDR_WIDTH - OFF_W;
    localparam int LINE_W = LINE_BYTES * 8;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;

    state_e                state_q, state_d;
    logic                  line_valid_q, line_valid_d;
    logic [TAG_W-1:0]      tag_q, tag_d;
    logic [LINE_W-1:0]     line_q, line_d;
    logic [31:0]           instr_q, instr_d;
    logic                  instr_valid_q, instr_valid_d;
    logic                  misaligned_q, misaligned_d;
    logic                  start_q, start_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [TAG_W-1:0]      pc_tag;
    logic                  hit;

    // Little-endian word pick: word k occupies bits [32k+31:32k] of the line.
    function automatic logic [31:0] sel_word(input logic [LINE_W-1:0]     l,
                                             input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] widx;
        logic [LINE_W-1:0]     sh;
        widx = (a & ADDR_WIDTH'(LINE_BYTES - 1)) >> 2;
        sh   = l >> {widx, 5'b0};
        return sh[31:0];
    endfunction

    assign pc_tag = pc[ADDR_WIDTH-1:OFF_W];
    assign hit    = line_valid_q && (tag_q == pc_tag);

    always_comb begin
        state_d       = state_q;
        line_valid_d  = line_valid_q;
        tag_d         = tag_q;
        line_d        = line_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        misaligned_d  = 1'b0;
        start_d       = start_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    line_valid_d = 1'b0;
                end else if (pc_valid) begin
                    if (pc[1:0] != 2'b00) begin
                        misaligned_d = 1'b1;
                    end else if (hit) begin
                        instr_d       = sel_word(line_q, pc);
                        instr_valid_d = 1'b1;
                    end else begin
                        start_d = 1'b1;
                        addr_d  = {pc_tag, {OFF_W{1'b0}}};
                        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (imem_read_rdy) begin
                    start_d = 1'b0;
                    state_d = IDLE;
                    if (flush) begin
                        line_valid_d = 1'b0;
                    end else begin
                        // Tag from the issued address; word from the pc seen now.
                        line_d        = imem_read_data;
                        tag_d         = addr_q[ADDR_WIDTH-1:OFF_W];
                        line_valid_d  = 1'b1;
                        instr_d       = sel_word(imem_read_data, pc);
                        instr_valid_d = 1'b1;
                    end
                end else if (flush) begin
                    line_valid_d = 1'b0;
                    state_d      = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_read_rdy) begin
                    start_d      = 1'b0;
                    line_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            line_valid_q  <= 1'b0;
            tag_q         <= '0;
            line_q        <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
            start_q       <= 1'b0;
            addr_q        <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            line_valid_q  <= line_valid_d;
            tag_q         <= tag_d;
            line_q        <= line_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            misaligned_q  <= misaligned_d;
            start_q       <= start_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
        end
    end

    assign instr           = instr_q;
    assign instr_valid     = instr_valid_q;
    assign misaligned      = misaligned_q;
    assign busy            = (state_q != IDLE);
    assign miss_count      = cnt_q;
    assign imem_read_start = start_q;
    assign imem_read_addr  = addr_q;
endmodule

// File: tb/tb_ifetch_line_buffer.sv
// Bench for ifetch_line_buffer: directed scenarios plus randomized fetch traffic
// checked against a one-line cache model and a pattern-based memory responder.
module tb_ifetch_line_buffer;
    localparam int AW = 32;
    localparam int LB = 16;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [AW-1:0]   pc = '0;
    logic            pc_valid = 1'b0;
    logic            flush = 1'b0;
    logic [31:0]     instr;
    logic            instr_valid;
    logic            misaligned;
    logic            busy;
    logic [CW-1:0]   miss_count;
    logic            imem_read_start;
    logic [AW-1:0]   imem_read_addr;
    logic [LB*8-1:0] imem_read_data = '0;
    logic            imem_read_rdy = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the buffer: which line is held, miss count, last delivered word.
    bit          m_valid = 1'b0;
    logic [27:0] m_tag = '0;
    int          m_cnt = 0;
    logic [31:0] m_last = '0;

    ifetch_line_buffer #(.ADDR_WIDTH(AW), .LINE_BYTES(LB), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid), .flush(flush),
        .instr(instr), .instr_valid(instr_valid), .misaligned(misaligned),
        .busy(busy), .miss_count(miss_count), .imem_read_start(imem_read_start),
        .imem_read_addr(imem_read_addr), .imem_read_data(imem_read_data),
        .imem_read_rdy(imem_read_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory contents: word k of the line at address la; line 0x40 holds 1,2,3,4.
    function automatic logic [31:0] mem_word(input logic [31:0] la, input int k);
        return 32'((la >> 2) - 32'd15 + 32'(k));
    endfunction

    function automatic logic [127:0] line_data(input logic [31:0] la);
        logic [127:0] d;
        for (int k = 0; k < 4; k++) d[32*k +: 32] = mem_word(la, k);
        return d;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return mem_word(a & 32'hFFFF_FFF0, int'((a >> 2) & 32'd3));
    endfunction

    function automatic logic [127:0] garbage();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One fetch request: dly idle REQ cycles before rdy, flush on wait cycle fl_at
    // (fl_at == dly puts flush together with rdy, negative means no flush).
    task automatic fetch(input logic [31:0] a, input int dly, input int fl_at);
        logic [31:0] la;
        bit          hit;
        bit          flushed;
        la       = a & 32'hFFFF_FFF0;
        hit      = m_valid && (m_tag == a[31:4]);
        pc       = a;
        pc_valid = 1'b1;
        flush    = 1'b0;
        step();
        if (a[1:0] != 2'b00) begin
            chk("mis_pulse", misaligned, 1);
            chk("mis_nostart", imem_read_start, 0);
            chk("mis_noinstr", instr_valid, 0);
            pc_valid = 1'b0;
            step();
            chk("mis_single", misaligned, 0);
            chk("mis_nostart2", imem_read_start, 0);
            return;
        end
        if (hit) begin
            m_last = exp_word(a);
            chk("hit_valid", instr_valid, 1);
            chk("hit_instr", instr, m_last);
            chk("hit_nostart", imem_read_start, 0);
            chk("hit_cnt", miss_count, m_cnt);
            pc_valid = 1'b0;
            return;
        end
        if (m_cnt < 255) m_cnt++;
        chk("miss_start", imem_read_start, 1);
        chk("miss_addr", imem_read_addr, la);
        chk("miss_busy", busy, 1);
        chk("miss_cnt", miss_count, m_cnt);
        chk("miss_noinstr", instr_valid, 0);
        flushed = 1'b0;
        for (int i = 0; i < dly; i++) begin
            flush          = (i == fl_at);
            imem_read_data = garbage();
            step();
            if (i == fl_at) flushed = 1'b1;
            flush = 1'b0;
            chk("req_hold", imem_read_start, 1);
            chk("req_addr", imem_read_addr, la);
            chk("req_busy", busy, 1);
            chk("req_noinstr", instr_valid, 0);
        end
        flush = (fl_at == dly);
        if (fl_at == dly) flushed = 1'b1;
        imem_read_rdy  = 1'b1;
        imem_read_data = line_data(la);
        step();
        imem_read_rdy  = 1'b0;
        imem_read_data = garbage();
        flush          = 1'b0;
        pc_valid       = 1'b0;
        chk("done_start", imem_read_start, 0);
        chk("done_busy", busy, 0);
        if (flushed) begin
            chk("flush_noinstr", instr_valid, 0);
            chk("flush_hold", instr, m_last);
            m_valid = 1'b0;
        end else begin
            m_last = exp_word(a);
            chk("fill_valid", instr_valid, 1);
            chk("fill_instr", instr, m_last);
            m_valid = 1'b1;
            m_tag   = a[31:4];
        end
    endtask

    task automatic idle_cycle();
        pc_valid = 1'b0;
        step();
        chk("idle_noinstr", instr_valid, 0);
        chk("idle_hold", instr, m_last);
        chk("idle_nostart", imem_read_start, 0);
    endtask

    task automatic flush_idle(input logic [31:0] a);
        pc       = a;
        pc_valid = 1'b1;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        pc_valid = 1'b0;
        chk("fidle_noinstr", instr_valid, 0);
        chk("fidle_nostart", imem_read_start, 0);
        chk("fidle_nomis", misaligned, 0);
        m_valid = 1'b0;
    endtask

    task automatic stray_rdy();
        pc_valid       = 1'b0;
        imem_read_rdy  = 1'b1;
        imem_read_data = garbage();
        step();
        imem_read_rdy = 1'b0;
        chk("stray_nostart", imem_read_start, 0);
        chk("stray_noinstr", instr_valid, 0);
        chk("stray_cnt", miss_count, m_cnt);
    endtask

    initial begin
        #1 reset = 1'b0;
        #12;
        chk("rst_instr", instr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_mis", misaligned, 0);
        chk("rst_start", imem_read_start, 0);
        chk("rst_addr", imem_read_addr, 0);
        chk("rst_cnt", miss_count, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1 reset = 1'b1;

        fetch(32'h40, 5, -1);
        fetch(32'h4C, 0, -1);
        fetch(32'h44, 0, -1);
        fetch(32'h48, 0, -1);
        idle_cycle();
        fetch(32'h50, 5, 2);
        fetch(32'h50, 2, -1);
        fetch(32'h54, 0, -1);
        fetch(32'h42, 0, -1);
        stray_rdy();
        fetch(32'h58, 0, -1);
        fetch(32'h60, 3, 3);
        fetch(32'h60, 1, 0);
        fetch(32'h60, 0, -1);
        flush_idle(32'h64);
        fetch(32'h64, 1, -1);

        // Asynchronous reset while a request is outstanding.
        flush_idle(32'h80);
        pc       = 32'h80;
        pc_valid = 1'b1;
        step();
        chk("ar_start", imem_read_start, 1);
        step();
        #2 reset = 1'b0;
        #1;
        chk("ar_start_drop", imem_read_start, 0);
        chk("ar_valid", instr_valid, 0);
        chk("ar_cnt", miss_count, 0);
        chk("ar_busy", busy, 0);
        chk("ar_instr", instr, 0);
        pc_valid = 1'b0;
        m_valid  = 1'b0;
        m_cnt    = 0;
        m_last   = '0;
        step();
        reset = 1'b1;

        for (int n = 0; n < 150; n++) begin
            int          r;
            int          dly;
            int          fl;
            logic [31:0] a;
            r = int'($urandom_range(0, 9));
            a = 32'h40 + 32'(16 * $urandom_range(0, 3)) + 32'(4 * $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            dly = int'($urandom_range(0, 4));
            fl  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, dly)) : -1;
            case (r)
                0:       flush_idle(a);
                1:       stray_rdy();
                2:       idle_cycle();
                default: fetch(a, dly, fl);
            endcase
        end

        // Drive the miss counter into saturation with alternating lines.
        for (int n = 0; n < 300 && m_cnt < 255; n++)
            fetch((n % 2 == 0) ? 32'h100 : 32'h110, 0, -1);
        for (int n = 0; n < 4; n++)
            fetch((n % 2 == 0) ? 32'h120 : 32'h130, int'($urandom_range(0, 2)), -1);
        chk("sat_cnt", miss_count, 255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
